// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Load-use stall / taken-branch squash sequencer for IF/ID and ID/EX
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int REGADDR_WIDTH   = 4,
    parameter int LU_STALL_CYCLES = 1,
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [REGADDR_WIDTH-1:0] id_rs,
    input  logic [REGADDR_WIDTH-1:0] id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     ex_mem_read,
    input  logic [REGADDR_WIDTH-1:0] ex_rt,
    input  logic                     ex_branch,
    input  logic                     ex_branch_taken,
    output logic                     pc_write,
    output logic                     if_id_write,
    output logic                     if_id_flush,
    output logic                     id_ex_flush,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     stall_cycles,
    output logic [CNT_WIDTH-1:0]     flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] c_lu_init = 3'(LU_STALL_CYCLES - 1);
    localparam logic [2:0] c_br_init = 3'(BR_FLUSH_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       w_br, w_lu, w_flush_evt;

    assign w_br = ex_branch & ex_branch_taken;
    assign w_lu = id_valid & ex_mem_read & (ex_rt != '0) &
                  ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flush_evt = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        case (r_state)
            RUN: begin
                if (w_br) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    w_flush_evt = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        w_state_nxt = BR_FLUSH;
                        w_cnt_nxt   = c_br_init;
                    end
                end else if (w_lu) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    if (LU_STALL_CYCLES > 1) begin
                        w_state_nxt = LU_STALL;
                        w_cnt_nxt   = c_lu_init;
                    end
                end
            end
            LU_STALL: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                w_cnt_nxt   = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_state_nxt = RUN;
            end
            BR_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                w_cnt_nxt   = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 3'd0;
            end
        endcase
        // Reset holds the pipeline frozen and fully squashed
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign busy = (r_state != RUN) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_cnt        <= 3'd0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (w_flush_evt && (flush_events != '1)) flush_events <= flush_events + 1'b1;
        end
    end

endmodule

`default_nettype wire
